// File: rtl/tpu_ctrl.sv
// tpu_ctrl: host-facing controller for a DIM x DIM systolic array.
// Decodes host requests into one-cycle strobes and row selects for memA,
// memB and the array's C buffer. It also runs the fixed-length compute
// sequence that is launched by a write to 0x400.
module tpu_ctrl #(
    parameter int DIM   = 8,
    parameter int ADDRW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   r_w,
    input  logic [ADDRW-1:0]       addr,
    output logic                   Aen,
    output logic                   AWrEn,
    output logic                   Ben,
    output logic                   SAEn,
    output logic                   SAWrEn,
    output logic [$clog2(DIM)-1:0] Arow,
    output logic [$clog2(DIM)-1:0] Crow,
    output logic                   Chalf,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int RW  = $clog2(DIM);
    localparam int SEQ = 3 * DIM - 2;      // cycles needed to drain a DIM x DIM wavefront
    localparam int CW  = $clog2(SEQ) + 1;

    localparam logic [CW-1:0]    LAST   = CW'(SEQ);
    localparam logic [ADDRW-1:0] A_LO   = ADDRW'(16'h100);
    localparam logic [ADDRW-1:0] A_HI   = ADDRW'(16'h13F);
    localparam logic [ADDRW-1:0] B_LO   = ADDRW'(16'h200);
    localparam logic [ADDRW-1:0] B_HI   = ADDRW'(16'h23F);
    localparam logic [ADDRW-1:0] C_LO   = ADDRW'(16'h300);
    localparam logic [ADDRW-1:0] C_HI   = ADDRW'(16'h37F);
    localparam logic [ADDRW-1:0] GO_ADR = ADDRW'(16'h400);

    typedef enum logic {
        IDLE,
        COMPUTE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Address window decode. The direction is qualified later, in the FSM.
    logic in_a, in_b, in_c, is_go;
    assign in_a  = (addr >= A_LO) && (addr <= A_HI);
    assign in_b  = (addr >= B_LO) && (addr <= B_HI);
    assign in_c  = (addr >= C_LO) && (addr <= C_HI);
    assign is_go = (addr == GO_ADR);

    // Controller FSM: request decode in IDLE, fixed-length sequence in COMPUTE.
    // NOTE: every state element uses <= so that all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            Aen       <= 1'b0;
            AWrEn     <= 1'b0;
            Ben       <= 1'b0;
            SAEn      <= 1'b0;
            SAWrEn    <= 1'b0;
            Arow      <= '0;
            Crow      <= '0;
            Chalf     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Strobes last one cycle unless a branch below re-asserts them.
            Aen    <= 1'b0;
            AWrEn  <= 1'b0;
            Ben    <= 1'b0;
            SAEn   <= 1'b0;
            SAWrEn <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req_valid && req_ready) begin
                        if (r_w && is_go) begin
                            state     <= COMPUTE;
                            cnt       <= CW'(1);
                            req_ready <= 1'b0;
                            Aen       <= 1'b1;
                            Ben       <= 1'b1;
                            SAEn      <= 1'b1;
                            busy      <= 1'b1;
                        end else if (r_w && in_a) begin
                            AWrEn <= 1'b1;
                            Arow  <= addr[3 +: RW];
                        end else if (r_w && in_b) begin
                            Ben <= 1'b1;
                        end else if (in_c) begin
                            // A read of C only steers the row mux. A write also strobes.
                            SAWrEn <= r_w;
                            Crow   <= addr[4 +: RW];
                            Chalf  <= addr[3];
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (cnt == LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        req_ready <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        Aen  <= 1'b1;
                        Ben  <= 1'b1;
                        SAEn <= 1'b1;
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_ctrl.sv
// tb_tpu_ctrl: the bench combines directed request vectors, hand-built compute and reset
// sequences, and random traffic. It checks every sampled cycle against a
// transaction-level model of the controller.
module tb_tpu_ctrl;

    localparam int DIM = 8;
    localparam int SEQ = 3 * DIM - 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] addr = '0;
    logic        req_ready, Aen, AWrEn, Ben, SAEn, SAWrEn, Chalf, busy, done, err;
    logic [2:0]  Arow, Crow;

    tpu_ctrl #(.DIM(DIM), .ADDRW(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .r_w(r_w), .addr(addr), .Aen(Aen), .AWrEn(AWrEn), .Ben(Ben), .SAEn(SAEn),
        .SAWrEn(SAWrEn), .Arow(Arow), .Crow(Crow), .Chalf(Chalf), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       done;
        logic       err;
        logic       aen;
        logic       awren;
        logic       ben;
        logic       saen;
        logic       sawren;
        logic [2:0] arow;
        logic [2:0] crow;
        logic       chalf;
    } outs_t;

    typedef struct packed {
        logic        rw;
        logic [15:0] a;
        logic        awren;
        logic        ben;
        logic        sawren;
        logic        err;
        logic [2:0]  arow;
        logic [2:0]  crow;
        logic        chalf;
    } vec_t;

    int passed = 0;
    int total  = 0;

    // Reference model state: remaining compute cycles and the last row selects.
    int m_left  = 0;
    int m_arow  = 0;
    int m_crow  = 0;
    int m_chalf = 0;

    function automatic outs_t sample();
        outs_t o;
        o.ready = req_ready; o.busy = busy; o.done = done; o.err = err;
        o.aen = Aen; o.awren = AWrEn; o.ben = Ben; o.saen = SAEn; o.sawren = SAWrEn;
        o.arow = Arow; o.crow = Crow; o.chalf = Chalf;
        return o;
    endfunction

    function automatic void model_reset();
        m_left = 0; m_arow = 0; m_crow = 0; m_chalf = 0;
    endfunction

    // Expected outputs after one rising edge, given the request present at that edge.
    function automatic outs_t model_step(input logic v, input logic rw, input logic [15:0] a);
        outs_t e = '0;
        logic  acc = v && (m_left == 0);
        if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left > 0) begin
                e.aen = 1; e.ben = 1; e.saen = 1; e.busy = 1;
            end else begin
                e.done = 1;
            end
        end
        if (acc) begin
            if (rw && a == 16'h400) begin
                m_left = SEQ;
                e.aen = 1; e.ben = 1; e.saen = 1; e.busy = 1;
            end else if (rw && a >= 16'h100 && a < 16'h140) begin
                e.awren = 1;
                m_arow  = (int'(a) - 'h100) / 8;
            end else if (rw && a >= 16'h200 && a < 16'h240) begin
                e.ben = 1;
            end else if (a >= 16'h300 && a < 16'h380) begin
                e.sawren = rw;
                m_crow   = (int'(a) - 'h300) / 16;
                m_chalf  = ((int'(a) - 'h300) / 8) % 2;
            end else begin
                e.err = 1;
            end
        end
        e.arow  = 3'(m_arow);
        e.crow  = 3'(m_crow);
        e.chalf = 1'(m_chalf);
        e.ready = (m_left == 0);
        return e;
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t exp_o);
        total++;
        if (got === exp_o) passed++;
        else $display("FAIL %s got=%b exp=%b (ready busy done err aen awren ben saen sawren arow crow chalf)",
                      name, got, exp_o);
    endtask

    task automatic check_int(input string name, input int got, input int exp_i);
        total++;
        if (got == exp_i) passed++;
        else $display("FAIL %s got=%0d exp=%0d", name, got, exp_i);
    endtask

    // Present a request for one edge, then compare the DUT with the model #1 after that edge.
    task automatic cycle(input string name, input logic v, input logic rw, input logic [15:0] a);
        req_valid = v; r_w = rw; addr = a;
        @(posedge clk);
        #1;
        check(name, sample(), model_step(v, rw, a));
    endtask

    function automatic vec_t mk(input logic rw, input logic [15:0] a, input logic aw,
                                input logic b, input logic sw, input logic e,
                                input logic [2:0] ar, input logic [2:0] cr, input logic ch);
        vec_t t;
        t.rw = rw; t.a = a; t.awren = aw; t.ben = b; t.sawren = sw; t.err = e;
        t.arow = ar; t.crow = cr; t.chalf = ch;
        return t;
    endfunction

    vec_t  vecs[14];
    outs_t idle_exp;
    int    busy_cnt, done_cnt;

    initial begin
        // Back-to-back single requests. The expected row selects carry the hold behaviour.
        vecs[0]  = mk(1, 16'h128, 1, 0, 0, 0, 3'd5, 3'd0, 0);
        vecs[1]  = mk(1, 16'h358, 0, 0, 1, 0, 3'd5, 3'd5, 1);
        vecs[2]  = mk(0, 16'h370, 0, 0, 0, 0, 3'd5, 3'd7, 0);
        vecs[3]  = mk(1, 16'h150, 0, 0, 0, 1, 3'd5, 3'd7, 0);
        vecs[4]  = mk(0, 16'h100, 0, 0, 0, 1, 3'd5, 3'd7, 0);
        vecs[5]  = mk(1, 16'h200, 0, 1, 0, 0, 3'd5, 3'd7, 0);
        vecs[6]  = mk(1, 16'h23F, 0, 1, 0, 0, 3'd5, 3'd7, 0);
        vecs[7]  = mk(1, 16'h13F, 1, 0, 0, 0, 3'd7, 3'd7, 0);
        vecs[8]  = mk(1, 16'h140, 0, 0, 0, 1, 3'd7, 3'd7, 0);
        vecs[9]  = mk(1, 16'h37F, 0, 0, 1, 0, 3'd7, 3'd7, 1);
        vecs[10] = mk(1, 16'h380, 0, 0, 0, 1, 3'd7, 3'd7, 1);
        vecs[11] = mk(0, 16'h400, 0, 0, 0, 1, 3'd7, 3'd7, 1);
        vecs[12] = mk(0, 16'h300, 0, 0, 0, 0, 3'd7, 3'd0, 0);
        vecs[13] = mk(0, 16'h23F, 0, 0, 0, 1, 3'd7, 3'd0, 0);

        idle_exp = '0;
        idle_exp.ready = 1'b1;

        // Reset state, sampled while reset is held across an edge.
        @(posedge clk);
        #1;
        check("reset_state", sample(), idle_exp);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, applied on consecutive edges starting at the first edge after release.
        for (int i = 0; i < 14; i++) begin
            outs_t e;
            req_valid = 1'b1; r_w = vecs[i].rw; addr = vecs[i].a;
            @(posedge clk);
            #1;
            void'(model_step(1'b1, vecs[i].rw, vecs[i].a));
            e = idle_exp;
            e.awren = vecs[i].awren; e.ben = vecs[i].ben; e.sawren = vecs[i].sawren;
            e.err = vecs[i].err; e.arow = vecs[i].arow; e.crow = vecs[i].crow;
            e.chalf = vecs[i].chalf;
            check($sformatf("vec%0d_%s_%h", i, vecs[i].rw ? "wr" : "rd", vecs[i].a), sample(), e);
        end
        cycle("idle_after_vecs", 0, 0, 16'h0);

        // Compute sequence with a B write held during COMPUTE. The write is taken in the done cycle.
        busy_cnt = 0; done_cnt = 0;
        cycle("go", 1, 1, 16'h400);
        busy_cnt += int'(busy);
        for (int k = 0; k < SEQ; k++) begin
            cycle($sformatf("hold_b_%0d", k), 1, 1, 16'h200);
            busy_cnt += int'(busy);
            done_cnt += int'(done);
        end
        check_int("done_at_n23", int'(done), 1);
        cycle("b_after_done", 1, 1, 16'h200);
        check_int("ben_after_done", int'(Ben && !busy), 1);
        cycle("idle_after_b", 0, 0, 16'h0);
        check_int("busy_len", busy_cnt, SEQ);
        check_int("done_count", done_cnt, 1);

        // A 0x400 write held continuously restarts compute in the done cycle with no gap.
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < SEQ + 2; k++) begin
            cycle($sformatf("restart_hold_%0d", k), 1, 1, 16'h400);
            busy_cnt += int'(busy);
            done_cnt += int'(done);
        end
        for (int k = 0; k < SEQ + 2; k++) begin
            cycle($sformatf("restart_run_%0d", k), 0, 0, 16'h0);
            busy_cnt += int'(busy);
            done_cnt += int'(done);
        end
        check_int("restart_busy_len", busy_cnt, 2 * SEQ);
        check_int("restart_done_count", done_cnt, 2);

        // Reset during compute cycle 10 aborts at once. A following 0x400 write runs a full sequence.
        cycle("rst_go", 1, 1, 16'h400);
        for (int k = 0; k < 9; k++) cycle($sformatf("rst_run_%0d", k), 0, 0, 16'h0);
        check_int("rst_mid_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_async", sample(), idle_exp);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            cycle($sformatf("post_rst_idle_%0d", k), 0, 0, 16'h0);
            done_cnt += int'(done);
        end
        check_int("no_done_after_abort", done_cnt, 0);
        busy_cnt = 0; done_cnt = 0;
        cycle("rst_rego", 1, 1, 16'h400);
        busy_cnt += int'(busy);
        for (int k = 0; k < SEQ + 1; k++) begin
            cycle($sformatf("rst_rego_run_%0d", k), 0, 0, 16'h0);
            busy_cnt += int'(busy);
            done_cnt += int'(done);
        end
        check_int("rego_busy_len", busy_cnt, SEQ);
        check_int("rego_done_count", done_cnt, 1);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            logic [15:0] a;
            logic        v, rw;
            v  = ($urandom_range(0, 3) != 0);
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       a = 16'h100 + 16'($urandom_range(0, 'h4F));
                1:       a = 16'h200 + 16'($urandom_range(0, 'h4F));
                2:       a = 16'h300 + 16'($urandom_range(0, 'h8F));
                3:       a = 16'h400;
                4:       a = 16'h3F8 + 16'($urandom_range(0, 'h10));
                default: a = 16'($urandom);
            endcase
            cycle($sformatf("rand_%0d", k), v, rw, a);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tpu_ctrl.md
TPU_CTRL -- requirements
Module: tpu_ctrl

Interface
REQ-001 SHALL have parameter DIM, default 8, meaning systolic array dimension (rows/cols).
REQ-002 SHALL have parameter ADDRW, default 16, meaning host address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid  input  1  host request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high at a rising edge.
REQ-007 SHALL have port r_w  input  1  0 = read, 1 = write.
REQ-008 SHALL have port addr  input  ADDRW  host address.
REQ-009 SHALL have ports Aen, AWrEn, Ben, SAEn, SAWrEn  output  1 each  registered strobes to memA, memB and the systolic array.
REQ-010 SHALL have ports Arow, Crow  output  $clog2(DIM) each  registered row selects.
REQ-011 SHALL have port Chalf  output  1  selects the upper or lower 64-bit half of a C row.
REQ-012 SHALL have port busy  output  1  high while in COMPUTE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at compute completion.
REQ-014 SHALL have port err  output  1  one-cycle pulse on an accepted request to an unmapped address.

Function
REQ-015 SHALL implement FSM states IDLE and COMPUTE; IDLE->COMPUTE on an accepted write to 0x400; COMPUTE->IDLE after the last compute cycle.
REQ-016 SHALL drive req_ready = 1 in IDLE and 0 in COMPUTE.
REQ-017 SHALL decode accepted requests in IDLE, driving the outputs on the following cycle for exactly one cycle. All strobes default to 0 when no request is accepted.
REQ-018 Write 0x100-0x13F SHALL assert AWrEn, with Arow = addr[5:3].
REQ-019 Write 0x200-0x23F SHALL assert Ben.
REQ-020 Write 0x300-0x37F SHALL assert SAWrEn, with Crow = addr[6:4] and Chalf = addr[3].
REQ-021 Read 0x300-0x37F SHALL set Crow = addr[6:4] and Chalf = addr[3] with no strobe asserted; the row selects SHALL hold until the next accepted C access.
REQ-022 Write 0x400 SHALL start the compute sequence.
REQ-023 An accepted request to any other address/direction combination (including reads of A/B and a read of 0x400) SHALL pulse err and cause no other effect.
REQ-024 Compute sequence: a 0x400 write accepted at edge N SHALL cause Aen, Ben and SAEn to be high for exactly 3*DIM-2 consecutive cycles, starting the cycle after N.
REQ-025 busy SHALL be high for exactly those same cycles.
REQ-026 done SHALL pulse high on the cycle immediately after the last SAEn cycle. req_ready SHALL return high on that same cycle.
REQ-027 The cycle counter SHALL be $clog2(3*DIM-2)+1 bits wide. It SHALL be 0 in IDLE, increment once per COMPUTE cycle, and SHALL NOT wrap.
REQ-028 The counter SHALL end the sequence when it reaches 3*DIM-2.
REQ-029 req_valid during COMPUTE SHALL be ignored (not accepted). The host SHALL hold the request, and it SHALL be accepted on the first cycle req_ready is high.
REQ-030 Arow, Crow and Chalf SHALL be unchanged by the compute sequence.
REQ-031 Back-to-back requests SHALL be accepted on consecutive cycles in IDLE. A request in the done cycle SHALL be accepted, and a new 0x400 write there SHALL restart compute with no gap.

Reset
REQ-032 On rst_n low, asynchronously: state = IDLE, counter = 0.
REQ-033 On rst_n low, asynchronously: all strobes, busy, done and err = 0, and Arow = Crow = Chalf = 0.
REQ-034 On rst_n low, req_ready SHALL be 1.
REQ-035 Reset asserted mid-COMPUTE SHALL abort the sequence immediately, with no done pulse.
REQ-036 After rst_n deasserts, the first request SHALL be accepted on the first rising edge with req_valid high.

Verification
REQ-037 DIM=8: write 0x128 -> next cycle AWrEn=1, Arow=5 for one cycle, other strobes 0.
REQ-038 Write 0x358, then read 0x370 -> SAWrEn=1 with Crow=5/Chalf=1, then SAEn=0 with Crow=7/Chalf=0.
REQ-039 Write 0x400 at edge N -> SAEn, Aen and Ben high for cycles N+1..N+22, busy identical, done at N+23, req_ready low for N+1..N+22.
REQ-040 Hold req_valid with write 0x200 during COMPUTE -> not accepted until the done cycle; Ben pulses on the cycle after done.
REQ-041 Write 0x150 and read 0x100 -> err pulses once each, no strobes.
REQ-042 Assert rst_n low at compute cycle 10 -> all outputs 0 and req_ready 1 immediately, no done pulse; a 0x400 write after release gives a full 22-cycle sequence.
